// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter that grants one of NUM_REQ requesters at a time
//          and forwards up to BURST_LEN of its words into a shared write FIFO.
// Latency: one IDLE cycle of arbitration before the first beat of each grant.
//          After that the design accepts one word per cycle.
// Backpressure: fifo_full deasserts req_ready and fifo_wr_en combinationally.
//               While it is high, the grant and the beat count are held.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   req_valid/req_data   per-requester word offer, slice i at [i*W +: W]
//   req_ready            per-requester accept, only the granted bit can be high
//   fifo_wr_en/fifo_din  write port toward the FIFO
//   fifo_full            FIFO full flag, in the same clock domain
//   grant_id             current grant, or the last one while idle
//   busy                 high while a grant is active
module fifo_wr_arbiter #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int NUM_REQ         = 4,
    parameter int BURST_LEN       = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0]         fifo_din,
    input  logic                               fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [GID_W-1:0]   last_grant;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_vld;
    logic [GID_W-1:0]   pick_idx;
    logic [GID_W-1:0]   cand;

    // Round-robin search starting just after last_grant. The loop walks from
    // the farthest candidate to the nearest one, so the nearest valid
    // requester is the last one assigned and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GID_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // The datapath is combinational from fifo_full. A stalled FIFO therefore
    // never sees a write, and the requester never sees a false accept.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        if (state == GRANT) begin
            req_ready[grant_id] = !fifo_full;
            fifo_wr_en          = req_valid[grant_id] && !fifo_full;
        end
    end

    assign fifo_din = req_data[int'(grant_id)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            grant_id   <= '0;
            // Pointing at the top index makes requester 0 the first one searched.
            last_grant <= GID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                        busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    // A requester that goes idle gives up the rest of its burst.
                    // The release always passes through IDLE, so there is no
                    // back-to-back grant.
                    if (!req_valid[grant_id]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int W  = 32;
    localparam int NR = 4;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_wr_en;
    logic [W-1:0]      fifo_din;
    logic              fifo_full;
    logic [1:0]        grant_id;
    logic              busy;

    int nvec;
    int nerr;
    int wr_cnt;
    int hs_cnt;
    int viol_cnt;
    int w0;

    fifo_wr_arbiter #(.FIFO_DATA_WIDTH(W), .NUM_REQ(NR), .BURST_LEN(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] dat(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    // Running tallies: writes, handshakes, and cycles that write into a full FIFO.
    always @(negedge clock) begin
        wr_cnt   += int'(fifo_wr_en);
        hs_cnt   += $countones(req_valid & req_ready);
        viol_cnt += int'(fifo_wr_en && fifo_full);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one clock cycle at the negedge, then advance to just after the next posedge.
    task automatic cyc(input string tag, input bit wr, input logic [3:0] rdy,
                       input logic [1:0] gid, input bit bsy);
        @(negedge clock);
        chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(wr));
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".gid"},   32'(grant_id), 32'(gid));
        chk({tag, ".busy"},  32'(busy), 32'(bsy));
        if (bsy) chk({tag, ".din"}, fifo_din, dat(int'(gid)));
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag, input logic [1:0] gid);
        cyc(tag, 1'b0, 4'b0000, gid, 1'b0);
    endtask

    task automatic burst(input string tag, input logic [1:0] gid, input int n);
        for (int b = 0; b < n; b++)
            cyc(tag, 1'b1, 4'b0001 << gid, gid, 1'b1);
    endtask

    task automatic do_reset();
        req_valid = '0;
        fifo_full = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        nvec = 0; nerr = 0; wr_cnt = 0; hs_cnt = 0; viol_cnt = 0; w0 = 0;
        reset     = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = dat(i);
        @(posedge clock); #1;
        @(posedge clock); #1;

        // Reset state, still inside reset.
        idle("rst", 2'd0);
        reset = 1'b0;

        // Two requesters alternate: 1, 3, then 1 again.
        req_valid = 4'b1010;
        idle("t1.arb0", 2'd0);
        burst("t1.g1", 2'd1, 8);
        idle("t1.arb1", 2'd1);
        burst("t1.g3", 2'd3, 8);
        idle("t1.arb2", 2'd3);
        burst("t1.g1b", 2'd1, 1);

        // All four requesters valid: order 0,1,2,3, then wrap to 0.
        do_reset();
        req_valid = 4'b1111;
        idle("t2.arb0", 2'd0);
        burst("t2.g0", 2'd0, 8);
        idle("t2.arb1", 2'd0);
        burst("t2.g1", 2'd1, 8);
        idle("t2.arb2", 2'd1);
        burst("t2.g2", 2'd2, 8);
        idle("t2.arb3", 2'd2);
        burst("t2.g3", 2'd3, 8);
        idle("t2.arb4", 2'd3);
        burst("t2.g0b", 2'd0, 1);

        // Requester 2 sends three words, then drops valid.
        // Afterwards 3 must beat 0, because 2 was granted last.
        do_reset();
        req_valid = 4'b0100;
        w0 = wr_cnt;
        idle("t3.arb", 2'd0);
        burst("t3.g2", 2'd2, 3);
        req_valid = 4'b0000;
        cyc("t3.rel", 1'b0, 4'b0100, 2'd2, 1'b1);
        chk("t3.writes", 32'(wr_cnt - w0), 32'd3);
        req_valid = 4'b1111;
        idle("t3.idle", 2'd2);
        burst("t3.next", 2'd3, 1);

        // Five full cycles after beat 4; the grant holds, then 8 writes in total.
        do_reset();
        req_valid = 4'b0010;
        w0 = wr_cnt;
        idle("t4.arb", 2'd0);
        burst("t4.pre", 2'd1, 4);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) cyc("t4.stall", 1'b0, 4'b0000, 2'd1, 1'b1);
        fifo_full = 1'b0;
        burst("t4.post", 2'd1, 4);
        idle("t4.end", 2'd1);
        chk("t4.writes", 32'(wr_cnt - w0), 32'd8);

        // Reset during beat 3, then the first grant goes to the lowest valid index.
        do_reset();
        req_valid = 4'b0010;
        idle("t5.arb", 2'd0);
        burst("t5.pre", 2'd1, 2);
        reset = 1'b1;
        burst("t5.beat3", 2'd1, 1);
        reset = 1'b0;
        req_valid = 4'b0110;
        idle("t5.postrst", 2'd0);
        burst("t5.g1", 2'd1, 1);
        req_valid = 4'b0000;
        cyc("t5.rel", 1'b0, 4'b0010, 2'd1, 1'b1);
        idle("t5.idle", 2'd1);

        chk("sb.wr_vs_hs", 32'(wr_cnt), 32'(hs_cnt));
        chk("sb.wr_when_full", 32'(viol_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_DATA_WIDTH, default 32: width of each requester data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-003 Parameter BURST_LEN, default 8: maximum words accepted per grant, legal range 1..256.
REQ-004 Port clock, input, 1: single clock for all logic.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, NUM_REQ: bit i high means requester i presents a word.
REQ-007 Port req_data, input, NUM_REQ*FIFO_DATA_WIDTH: requester i word in slice [i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH].
REQ-008 Port req_ready, output, NUM_REQ: bit i high means a word from requester i is accepted this cycle if req_valid[i] is high.
REQ-009 Port fifo_wr_en, output, 1: FIFO write enable.
REQ-010 Port fifo_din, output, FIFO_DATA_WIDTH: FIFO write data.
REQ-011 Port fifo_full, input, 1: FIFO full flag, same clock domain.
REQ-012 Port grant_id, output, $clog2(NUM_REQ): index of the currently or last granted requester.
REQ-013 Port busy, output, 1: high while in state GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE with any req_valid bit high, the block SHALL select the first requester with req_valid high, searching from last_grant+1 upward modulo NUM_REQ. It SHALL load grant_id and last_grant with that index, clear beat_cnt, and enter GRANT on the next edge.
REQ-016 In IDLE, all req_ready bits and fifo_wr_en SHALL be 0. Arbitration latency SHALL be one cycle from req_valid to first possible acceptance.
REQ-017 In GRANT, req_ready[grant_id] SHALL equal !fifo_full, and all other req_ready bits SHALL be 0. These are combinational from fifo_full.
REQ-018 In GRANT, fifo_wr_en SHALL equal req_valid[grant_id] && !fifo_full. fifo_din SHALL equal the req_data slice of grant_id in the same cycle.
REQ-019 Each cycle with fifo_wr_en high SHALL be one beat, and beat_cnt SHALL increment by 1.
REQ-020 Ending a grant:
- Trigger: a beat occurs with beat_cnt == BURST_LEN-1, or req_valid[grant_id] is low in GRANT.
- The block SHALL return to IDLE on the next edge.
- Another grant SHALL NOT start in that same cycle.
REQ-021 While fifo_full is high in GRANT with req_valid[grant_id] high, the block SHALL hold the grant, keep beat_cnt unchanged and issue no write. There is no timeout.
REQ-022 When the grant ends, last_grant SHALL keep the released index, so that index has lowest priority in the next arbitration.
REQ-023 Round-robin search SHALL wrap from NUM_REQ-1 to 0.
REQ-024 grant_id SHALL hold its value in IDLE until the next grant.
REQ-025 fifo_wr_en SHALL never be high while fifo_full is high.
REQ-026 Exactly one word SHALL be written per accepted req_valid&&req_ready handshake. Words SHALL NOT be dropped or duplicated.
REQ-027 beat_cnt SHALL be $clog2(BURST_LEN+1) bits wide and SHALL NOT wrap within a grant.

Reset
REQ-028 On reset high at a clock edge, the block SHALL set:
- state IDLE, beat_cnt 0, grant_id 0, last_grant NUM_REQ-1, busy 0;
- outputs so that req_ready is all 0 and fifo_wr_en is 0 in the following cycle.
REQ-029 Reset asserted mid-burst SHALL abort the grant without further writes. The first post-reset grant SHALL go to the lowest-index valid requester.

Verification
REQ-030 After reset, req_valid=4'b1010 held, fifo_full=0 -> grant_id=1 first. It accepts 8 beats, one per cycle (fifo_wr_en high 8 consecutive cycles), then one IDLE cycle, then grant_id=3 for 8 beats, then grant_id=1.
REQ-031 All four requesters continuously valid -> grant order 0,1,2,3,0 with 8 beats each, and fifo_din always matches the granted slice.
REQ-032 Requester 2 alone sends 3 words then drops valid -> 3 writes, grant released, busy low the next cycle, and last_grant=2.
REQ-033 fifo_full is raised for 5 cycles mid-burst after beat 4 -> fifo_wr_en and req_ready stay 0 for 5 cycles with grant held. Beats 5..8 then complete, for a total of 8 writes.
REQ-034 Reset asserted during beat 3 of requester 1's grant -> no write in the following cycle and req_ready=0. After release with req_valid=4'b0110, the grant goes to requester 1.
REQ-035 Scoreboard on all runs: count of fifo_wr_en cycles equals the sum of per-requester handshakes. fifo_wr_en && fifo_full is never true.
